// File: rtl/sdcard_pkg.sv
// Shared encodings for the SD-card block queue: pi1 op codes, command
// register indices and RESET status codes.
package sdcard_pkg;

    typedef enum logic [1:0] {
        OP_NOOP = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } pi1_op_t;

    typedef enum logic [2:0] {
        CMDRESET = 3'd0,
        CMDSWAP  = 3'd1,
        CMDREAD  = 3'd2,
        CMDWRITE = 3'd3,
        CMDQSTAT = 3'd4
    } cmd_t;

    localparam int CMD_CNT = 5;

    typedef enum logic [1:0] {
        STATUSPOWEROFF = 2'd0,
        STATUSREADY    = 2'd1,
        STATUSBUSY     = 2'd2,
        STATUSERROR    = 2'd3
    } status_t;

endpackage

// File: rtl/sdcard_blkbuf.sv
// Block buffer RAM: one clock, async reads, byte-enable port A (CPU) and
// full-word port B (phy). On a same-word collision port A's bytes win.
module sdcard_blkbuf #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic            clk,
    input  logic [AW-1:0]   a_addr,
    input  logic            a_we,
    input  logic [DW/8-1:0] a_sel,
    input  logic [DW-1:0]   a_wdata,
    output logic [DW-1:0]   a_rdata,
    input  logic [AW-1:0]   b_addr,
    input  logic            b_we,
    input  logic [DW-1:0]   b_wdata,
    output logic [DW-1:0]   b_rdata
);

    logic [DW-1:0] mem [1<<AW];

    assign a_rdata = mem[a_addr];
    assign b_rdata = mem[b_addr];

    // Port A is assigned last so its selected bytes override port B.
    always_ff @(posedge clk) begin
        if (b_we)
            mem[b_addr] <= b_wdata;
        if (a_we)
            for (int unsigned i = 0; i < DW/8; i++)
                if (a_sel[i])
                    mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end

endmodule

// File: rtl/sdcard_blkq.sv
// Multi-buffer SD-card block queue between the pi1 slave port and the phy:
// BUFCNT block buffers, BUFCNT-deep command queue, completion interrupts.
module sdcard_blkq
    import sdcard_pkg::*;
#(
    parameter int ARCHBITSZ = 32,
    parameter int PHYBLKSZ  = 512,
    parameter int BUFCNT    = 4,
    localparam int AW       = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             pi1_op_i,
    input  logic [AW-1:0]          pi1_addr_i,
    input  logic [ARCHBITSZ-1:0]   pi1_data_i,
    output logic [ARCHBITSZ-1:0]   pi1_data_o,
    input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
    output logic                   pi1_rdy_o,
    output logic [AW-1:0]          pi1_mapsz_o,
    output logic                   phy_rst_o,
    input  logic                   phy_cmd_pop_i,
    output logic                   phy_cmd_data_o,
    output logic [AW-1:0]          phy_cmd_addr_o,
    output logic                   phy_cmd_empty_o,
    input  logic                   phy_rx_push_i,
    input  logic [7:0]             phy_rx_data_i,
    input  logic                   phy_tx_pop_i,
    output logic [7:0]             phy_tx_data_o,
    input  logic [AW-1:0]          phy_blkcnt_i,
    input  logic                   phy_err_i,
    output logic                   intrqst_o,
    input  logic                   intrdy_i
);

    localparam int BW    = ARCHBITSZ/8;
    localparam int LW    = $clog2(BW);
    localparam int MAPSZ = PHYBLKSZ/BW;
    localparam int WIDX  = $clog2(MAPSZ);
    localparam int BIDX  = $clog2(BUFCNT);
    localparam int BPW   = $clog2(PHYBLKSZ);
    localparam int CW    = $clog2(BUFCNT+1);

    pi1_op_t                op;
    cmd_t                   cmd;
    status_t                status;
    logic                   is_cmd, buf_we, do_enq, do_pop, do_flush, full, empty;
    logic [ARCHBITSZ-1:0]   cmd_resp, a_rdata, b_rdata, b_wdata;
    logic [31:0]            qstat;

    logic [BIDX-1:0]        cpubuf, phybuf, head, tail;
    logic [CW-1:0]          count;
    logic                   q_dir  [BUFCNT];
    logic [BIDX-1:0]        q_buf  [BUFCNT];
    logic [AW-1:0]          q_addr [BUFCNT];
    logic                   overflow, phy_rst_q, pending, idle_q, err_q, intrdy_q, intrqst;
    logic [BPW-1:0]         bptr;
    logic [ARCHBITSZ-9:0]   rx_sr;
    logic                   compl, int_event;

    assign op       = pi1_op_t'(pi1_op_i);
    assign cmd      = cmd_t'(pi1_addr_i[2:0]);
    assign is_cmd   = (op == OP_RW) && (pi1_addr_i < AW'(CMD_CNT));
    assign buf_we   = (op == OP_WR) || ((op == OP_RW) && !is_cmd);
    assign empty    = (count == '0);
    assign full     = (count == CW'(BUFCNT));
    assign do_enq   = is_cmd && ((cmd == CMDREAD) || (cmd == CMDWRITE)) && !full;
    assign do_pop   = phy_cmd_pop_i && !empty;
    assign do_flush = is_cmd && (cmd == CMDRESET) && (|pi1_data_i);

    assign pi1_rdy_o       = 1'b1;
    assign pi1_mapsz_o     = AW'(MAPSZ);
    assign phy_rst_o       = rst_i || phy_rst_q;
    assign phy_cmd_data_o  = q_dir[head];
    assign phy_cmd_addr_o  = q_addr[head];
    assign phy_cmd_empty_o = empty;
    assign intrqst_o       = intrqst;

    sdcard_blkbuf #(
        .DW (ARCHBITSZ),
        .AW (BIDX + WIDX)
    ) u_buf (
        .clk     (clk_i),
        .a_addr  ({cpubuf, pi1_addr_i[WIDX-1:0]}),
        .a_we    (buf_we),
        .a_sel   (pi1_sel_i),
        .a_wdata (pi1_data_i),
        .a_rdata (a_rdata),
        .b_addr  ({phybuf, bptr[BPW-1:LW]}),
        .b_we    (phy_rx_push_i && (&bptr[LW-1:0])),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

    assign b_wdata       = {phy_rx_data_i, rx_sr};
    assign phy_tx_data_o = b_rdata[{bptr[LW-1:0], 3'b000} +: 8];

    always_comb begin
        status = STATUSREADY;
        if (phy_err_i)
            status = STATUSERROR;
        else if (!empty || !phy_cmd_pop_i)
            status = STATUSBUSY;
    end

    assign qstat = {15'd0, overflow, 8'(cpubuf), 8'(count)};

    always_comb begin
        cmd_resp = '0;
        case (cmd)
            CMDRESET:          cmd_resp = ARCHBITSZ'(status);
            CMDSWAP:           cmd_resp = ARCHBITSZ'(PHYBLKSZ);
            CMDREAD, CMDWRITE: cmd_resp = full ? '1 : ARCHBITSZ'(phy_blkcnt_i);
            CMDQSTAT:          cmd_resp = ARCHBITSZ'(qstat);
            default:           cmd_resp = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pi1_data_o <= '0;
        end else begin
            case (op)
                OP_RD:   pi1_data_o <= a_rdata;
                OP_RW:   pi1_data_o <= is_cmd ? cmd_resp : a_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpubuf    <= '0;
            overflow  <= 1'b0;
            phy_rst_q <= 1'b0;
        end else begin
            phy_rst_q <= do_flush;
            if (is_cmd && (cmd == CMDSWAP))
                cpubuf <= cpubuf + 1'b1;
            if (do_flush || (is_cmd && (cmd == CMDQSTAT)))
                overflow <= 1'b0;
            else if (is_cmd && ((cmd == CMDREAD) || (cmd == CMDWRITE)) && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq)
                tail <= tail + 1'b1;
            if (do_pop)
                head <= head + 1'b1;
            count <= count + CW'(do_enq) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_enq) begin
            q_dir[tail]  <= (cmd == CMDWRITE);
            q_buf[tail]  <= cpubuf;
            q_addr[tail] <= AW'(pi1_data_i);
        end
    end

    // The popped entry's buffer is latched so the phy keeps its buffer
    // while the head pointer moves on to the next queued command.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phybuf <= '0;
            bptr   <= '0;
            rx_sr  <= '0;
        end else begin
            if (do_pop) begin
                phybuf <= q_buf[head];
                bptr   <= '0;
            end else if (phy_rx_push_i || phy_tx_pop_i) begin
                bptr <= bptr + 1'b1;
            end
            if (phy_rx_push_i)
                rx_sr <= b_wdata[ARCHBITSZ-1:8];
        end
    end

    assign compl     = pending && phy_cmd_pop_i && !idle_q;
    assign int_event = compl || (phy_err_i && !err_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending  <= 1'b0;
            idle_q   <= 1'b1;
            err_q    <= 1'b0;
            intrdy_q <= 1'b0;
            intrqst  <= 1'b0;
        end else begin
            idle_q   <= phy_cmd_pop_i;
            err_q    <= phy_err_i;
            intrdy_q <= intrdy_i;
            if (do_pop)
                pending <= 1'b1;
            else if (compl || do_flush)
                pending <= 1'b0;
            if (intrqst && intrdy_q && !intrdy_i)
                intrqst <= 1'b0;
            else if (!intrqst && int_event)
                intrqst <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdcard_blkq.sv
// Self-checking bench for sdcard_blkq: table of pi1 vectors plus hand-written
// tx, queue-overflow, rx, error and reset sequences.
module tb_sdcard_blkq;

    localparam int AW = 30;
    localparam logic [AW-1:0] BLK = 30'h0001_2345;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [1:0]    pi1_op_i;
    logic [AW-1:0] pi1_addr_i;
    logic [31:0]   pi1_data_i, pi1_data_o;
    logic [3:0]    pi1_sel_i;
    logic          pi1_rdy_o;
    logic [AW-1:0] pi1_mapsz_o, phy_cmd_addr_o;
    logic          phy_rst_o, phy_cmd_pop_i, phy_cmd_data_o, phy_cmd_empty_o;
    logic          phy_rx_push_i, phy_tx_pop_i, phy_err_i, intrqst_o, intrdy_i;
    logic [7:0]    phy_rx_data_i, phy_tx_data_o;

    int ncmp = 0;
    int nerr = 0;
    logic [31:0] sb[$];
    logic [7:0]  txq[$];

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    sel;
        bit            chk;
        logic [31:0]   exp;
        string         name;
    } vec_t;
    vec_t tbl[14];

    sdcard_blkq #(.ARCHBITSZ(32), .PHYBLKSZ(512), .BUFCNT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i), .pi1_data_i(pi1_data_i),
        .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i), .pi1_rdy_o(pi1_rdy_o),
        .pi1_mapsz_o(pi1_mapsz_o), .phy_rst_o(phy_rst_o),
        .phy_cmd_pop_i(phy_cmd_pop_i), .phy_cmd_data_o(phy_cmd_data_o),
        .phy_cmd_addr_o(phy_cmd_addr_o), .phy_cmd_empty_o(phy_cmd_empty_o),
        .phy_rx_push_i(phy_rx_push_i), .phy_rx_data_i(phy_rx_data_i),
        .phy_tx_pop_i(phy_tx_pop_i), .phy_tx_data_o(phy_tx_data_o),
        .phy_blkcnt_i(BLK), .phy_err_i(phy_err_i),
        .intrqst_o(intrqst_o), .intrdy_i(intrdy_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pi1(input logic [1:0] op, input logic [AW-1:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input bit chk, input logic [31:0] exp, input string name);
        logic [31:0] e;
        pi1_op_i = op; pi1_addr_i = addr; pi1_data_i = data; pi1_sel_i = sel;
        if (chk) sb.push_back(exp);
        cyc();
        pi1_op_i = 2'b00;
        if (chk) begin
            e = sb.pop_front();
            check(name, {32'd0, pi1_data_o}, {32'd0, e});
        end
    endtask

    initial begin
        rst_i = 1'b1; pi1_op_i = '0; pi1_addr_i = '0; pi1_data_i = '0; pi1_sel_i = '0;
        phy_cmd_pop_i = 1'b1; phy_rx_push_i = 1'b0; phy_rx_data_i = '0;
        phy_tx_pop_i = 1'b0; phy_err_i = 1'b0; intrdy_i = 1'b1;

        tbl[0]  = '{2'b11, 30'd0,   32'd0,         4'hF, 1'b1, 32'd1,         "reset_status"};
        tbl[1]  = '{2'b11, 30'd4,   32'd0,         4'hF, 1'b1, 32'd0,         "qstat_init"};
        tbl[2]  = '{2'b11, 30'd1,   32'd0,         4'hF, 1'b1, 32'd512,       "swap_ret"};
        tbl[3]  = '{2'b11, 30'd4,   32'd0,         4'hF, 1'b1, 32'h100,       "qstat_cpubuf1"};
        tbl[4]  = '{2'b11, 30'd1,   32'd0,         4'hF, 1'b1, 32'd512,       "swap_ret"};
        tbl[5]  = '{2'b11, 30'd1,   32'd0,         4'hF, 1'b1, 32'd512,       "swap_ret"};
        tbl[6]  = '{2'b11, 30'd1,   32'd0,         4'hF, 1'b1, 32'd512,       "swap_ret"};
        tbl[7]  = '{2'b11, 30'd4,   32'd0,         4'hF, 1'b1, 32'd0,         "qstat_wrap"};
        tbl[8]  = '{2'b01, 30'd0,   32'd0,         4'hF, 1'b0, 32'd0,         "wr_clear"};
        tbl[9]  = '{2'b01, 30'd128, 32'hAABBCCDD,  4'h2, 1'b0, 32'd0,         "wr_sel"};
        tbl[10] = '{2'b10, 30'd0,   32'd0,         4'hF, 1'b1, 32'h0000CC00,  "byte_sel"};
        tbl[11] = '{2'b01, 30'd2,   32'h11112222,  4'hF, 1'b0, 32'd0,         "wr_word2"};
        tbl[12] = '{2'b11, 30'd130, 32'h33334444,  4'hF, 1'b1, 32'h11112222,  "rw_old"};
        tbl[13] = '{2'b10, 30'd2,   32'd0,         4'hF, 1'b1, 32'h33334444,  "rw_new"};

        cyc(); cyc(); cyc();
        rst_i = 1'b0;
        cyc();
        check("rst_data", {32'd0, pi1_data_o}, 64'd0);
        check("rst_intrqst", {63'd0, intrqst_o}, 64'd0);
        check("rst_phy_rst", {63'd0, phy_rst_o}, 64'd0);
        check("rst_empty", {63'd0, phy_cmd_empty_o}, 64'd1);
        check("mapsz", {34'd0, pi1_mapsz_o}, 64'd128);
        check("rdy", {63'd0, pi1_rdy_o}, 64'd1);

        for (int i = 0; i < 14; i++)
            pi1(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].sel, tbl[i].chk, tbl[i].exp, tbl[i].name);

        // tx: fill buffer 0, queue a WRITE, stream it out.
        for (int w = 0; w < 128; w++) begin
            logic [31:0] d;
            for (int b = 0; b < 4; b++) begin
                d[b*8 +: 8] = 8'((4*w + b) & 255);
                txq.push_back(8'((4*w + b) & 255));
            end
            pi1(2'b01, AW'(w), d, 4'hF, 1'b0, 32'd0, "fill");
        end
        pi1(2'b11, 30'd3, 32'h10, 4'hF, 1'b1, {2'b00, BLK}, "write_cmd");
        check("cmd_empty", {63'd0, phy_cmd_empty_o}, 64'd0);
        check("cmd_dir", {63'd0, phy_cmd_data_o}, 64'd1);
        check("cmd_addr", {34'd0, phy_cmd_addr_o}, 64'h10);
        cyc();
        phy_cmd_pop_i = 1'b0;
        check("popped_empty", {63'd0, phy_cmd_empty_o}, 64'd1);
        phy_tx_pop_i = 1'b1;
        for (int k = 0; k < 512; k++) begin
            logic [7:0] eb;
            eb = txq.pop_front();
            check("tx_byte", {56'd0, phy_tx_data_o}, {56'd0, eb});
            cyc();
        end
        phy_tx_pop_i = 1'b0;
        check("int_before_done", {63'd0, intrqst_o}, 64'd0);
        phy_cmd_pop_i = 1'b1;
        cyc();
        check("int_done", {63'd0, intrqst_o}, 64'd1);
        intrdy_i = 1'b0; cyc();
        check("int_ack", {63'd0, intrqst_o}, 64'd0);
        intrdy_i = 1'b1; cyc();

        // Queue fill and overflow with the phy held busy.
        phy_cmd_pop_i = 1'b0; cyc();
        for (int i = 0; i < 4; i++) begin
            pi1(2'b11, 30'd2, 32'(100 + i), 4'hF, 1'b1, {2'b00, BLK}, "read_cmd");
            if (i < 3) pi1(2'b11, 30'd1, 32'd0, 4'hF, 1'b1, 32'd512, "swap_ret");
        end
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'h0304, "qstat_full");
        pi1(2'b11, 30'd2, 32'd200, 4'hF, 1'b1, 32'hFFFFFFFF, "read_overflow");
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'h10304, "qstat_ovf");
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'h0304, "qstat_ovf_clr");
        pi1(2'b11, 30'd0, 32'd0, 4'hF, 1'b1, 32'd2, "status_busy");

        // Pop entries for buffers 0, 1, 2; phy then receives into buffer 2.
        for (int i = 0; i < 3; i++) begin
            phy_cmd_pop_i = 1'b1; cyc();
            phy_cmd_pop_i = 1'b0; cyc();
        end
        check("cmd_rd_dir", {63'd0, phy_cmd_data_o}, 64'd0);
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'h0301, "qstat_drain");
        phy_rx_push_i = 1'b1;
        for (int k = 0; k < 512; k++) begin
            phy_rx_data_i = 8'(k & 255);
            cyc();
        end
        phy_rx_push_i = 1'b0;
        for (int i = 0; i < 3; i++) pi1(2'b11, 30'd1, 32'd0, 4'hF, 1'b1, 32'd512, "swap_ret");
        pi1(2'b10, 30'd0,   32'd0, 4'hF, 1'b1, 32'h03020100, "rx_w0");
        pi1(2'b10, 30'd1,   32'd0, 4'hF, 1'b1, 32'h07060504, "rx_w1");
        pi1(2'b10, 30'd64,  32'd0, 4'hF, 1'b1, 32'h03020100, "rx_w64");
        pi1(2'b10, 30'd127, 32'd0, 4'hF, 1'b1, 32'hFFFEFDFC, "rx_w127");

        // Phy error, then RESET flush.
        intrdy_i = 1'b0; cyc();
        intrdy_i = 1'b1; cyc();
        check("int_clear2", {63'd0, intrqst_o}, 64'd0);
        phy_err_i = 1'b1; cyc();
        check("int_err", {63'd0, intrqst_o}, 64'd1);
        pi1(2'b11, 30'd0, 32'd0, 4'hF, 1'b1, 32'd3, "status_err");
        pi1(2'b11, 30'd0, 32'd1, 4'hF, 1'b1, 32'd3, "reset_cmd");
        check("phy_rst_pulse", {63'd0, phy_rst_o}, 64'd1);
        check("flush_empty", {63'd0, phy_cmd_empty_o}, 64'd1);
        cyc();
        check("phy_rst_end", {63'd0, phy_rst_o}, 64'd0);
        phy_err_i = 1'b0;
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'h0200, "qstat_flushed");
        phy_cmd_pop_i = 1'b1; cyc();
        pi1(2'b11, 30'd0, 32'd0, 4'hF, 1'b1, 32'd1, "status_ready");

        // rst_i mid-transfer.
        phy_cmd_pop_i = 1'b0;
        pi1(2'b11, 30'd3, 32'h20, 4'hF, 1'b1, {2'b00, BLK}, "write_cmd2");
        rst_i = 1'b1; #1;
        check("phy_rst_in_rst", {63'd0, phy_rst_o}, 64'd1);
        cyc(); cyc();
        rst_i = 1'b0; cyc();
        check("rst2_data", {32'd0, pi1_data_o}, 64'd0);
        check("rst2_intrqst", {63'd0, intrqst_o}, 64'd0);
        check("rst2_empty", {63'd0, phy_cmd_empty_o}, 64'd1);
        check("rst2_phy_rst", {63'd0, phy_rst_o}, 64'd0);
        pi1(2'b11, 30'd4, 32'd0, 4'hF, 1'b1, 32'd0, "qstat_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
